// File: rtl/lemmings_pkg.sv
// lemmings_pkg: shared lemming state encoding and per-lemming output bundle.
package lemmings_pkg;
    typedef enum logic [3:0] {
        WALK_L, WALK_R, JUMP_L, JUMP_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT
    } state_t;
    typedef struct packed {
        logic walk_left;
        logic walk_right;
        logic aah;
        logic digging;
        logic jumping;
        logic splat;
    } lemming_out_t;
    function automatic lemming_out_t decode(input state_t s);
        lemming_out_t o;
        o.walk_left  = s == WALK_L;
        o.walk_right = s == WALK_R;
        o.aah        = s == FALL_L || s == FALL_R;
        o.digging    = s == DIG_L || s == DIG_R;
        o.jumping    = s == JUMP_L || s == JUMP_R;
        o.splat      = s == SPLAT;
        return o;
    endfunction
endpackage

// File: rtl/lemmings_array_if.sv
// lemmings_array_if: per-lemming sensor inputs and state outputs for the lemming array.
interface lemmings_array_if #(parameter int NUM_LEMMINGS = 4);
    localparam int CW = $clog2(NUM_LEMMINGS + 1);
    logic [NUM_LEMMINGS-1:0] bump_left, bump_right, small_bump_left, small_bump_right, ground, dig;
    logic [NUM_LEMMINGS-1:0] walk_left, walk_right, aah, digging, jumping, splat;
    logic [CW-1:0]           alive_count;
    modport master (
        output bump_left, bump_right, small_bump_left, small_bump_right, ground, dig,
        input  walk_left, walk_right, aah, digging, jumping, splat, alive_count
    );
    modport slave (
        input  bump_left, bump_right, small_bump_left, small_bump_right, ground, dig,
        output walk_left, walk_right, aah, digging, jumping, splat, alive_count
    );
endinterface

// File: rtl/lemming_fsm.sv
// lemming_fsm: one lemming's Moore machine with jump timer and fall-duration death rule.
module lemming_fsm
    import lemmings_pkg::*;
#(
    parameter int SPLAT_CYCLES = 20,
    parameter int JUMP_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         bump_left,
    input  logic         bump_right,
    input  logic         small_bump_left,
    input  logic         small_bump_right,
    input  logic         ground,
    input  logic         dig,
    output lemming_out_t o
);
    localparam int FW = $clog2(SPLAT_CYCLES + 1);
    localparam int JW = JUMP_CYCLES > 1 ? $clog2(JUMP_CYCLES) : 1;
    localparam logic [FW-1:0] FALL_MAX  = FW'(SPLAT_CYCLES);
    localparam logic [JW-1:0] JUMP_LAST = JW'(JUMP_CYCLES - 1);
    state_t        state, state_nxt;
    logic [FW-1:0] fall_cnt, fall_nxt;
    logic [JW-1:0] jump_cnt, jump_nxt;
    logic          falling, in_jump, jump_last;
    always_ff @(posedge clk or negedge areset_n)
        if (!areset_n) begin
            state    <= WALK_L;
            fall_cnt <= '0;
            jump_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fall_cnt <= fall_nxt;
            jump_cnt <= jump_nxt;
        end
    always_comb begin
        falling   = state == FALL_L || state == FALL_R;
        in_jump   = state == JUMP_L || state == JUMP_R;
        jump_last = jump_cnt == JUMP_LAST;
        state_nxt = state;
        case (state)
            WALK_L:  state_nxt = !ground ? FALL_L : dig ? DIG_L : bump_left ? WALK_R
                               : small_bump_left ? JUMP_L : WALK_L;
            WALK_R:  state_nxt = !ground ? FALL_R : dig ? DIG_R : bump_right ? WALK_L
                               : small_bump_right ? JUMP_R : WALK_R;
            JUMP_L:  state_nxt = !jump_last ? JUMP_L : ground ? WALK_L : FALL_L;
            JUMP_R:  state_nxt = !jump_last ? JUMP_R : ground ? WALK_R : FALL_R;
            FALL_L:  state_nxt = !ground ? FALL_L : fall_cnt >= FALL_MAX ? SPLAT : WALK_L;
            FALL_R:  state_nxt = !ground ? FALL_R : fall_cnt >= FALL_MAX ? SPLAT : WALK_R;
            DIG_L:   state_nxt = ground ? DIG_L : FALL_L;
            DIG_R:   state_nxt = ground ? DIG_R : FALL_R;
            default: state_nxt = state;
        endcase
        // counters only run while their state persists, so every entry starts from zero
        fall_nxt = falling && !ground ? (fall_cnt == FALL_MAX ? fall_cnt : fall_cnt + 1'b1) : '0;
        jump_nxt = in_jump && !jump_last ? jump_cnt + 1'b1 : '0;
        o        = decode(state);
    end
endmodule

// File: rtl/lemmings_array.sv
// lemmings_array: NUM_LEMMINGS independent lemming controllers plus a live-lemming count.
module lemmings_array
    import lemmings_pkg::*;
#(
    parameter int NUM_LEMMINGS = 4,
    parameter int SPLAT_CYCLES = 20,
    parameter int JUMP_CYCLES  = 2
) (
    input logic            clk,
    input logic            areset_n,
    lemmings_array_if.slave s
);
    localparam int CW = $clog2(NUM_LEMMINGS + 1);
    lemming_out_t o [NUM_LEMMINGS];
    for (genvar g = 0; g < NUM_LEMMINGS; g++) begin : g_lem
        lemming_fsm #(.SPLAT_CYCLES(SPLAT_CYCLES), .JUMP_CYCLES(JUMP_CYCLES)) u_fsm (
            .clk              (clk),
            .areset_n         (areset_n),
            .bump_left        (s.bump_left[g]),
            .bump_right       (s.bump_right[g]),
            .small_bump_left  (s.small_bump_left[g]),
            .small_bump_right (s.small_bump_right[g]),
            .ground           (s.ground[g]),
            .dig              (s.dig[g]),
            .o                (o[g])
        );
    end
    always_comb begin
        s.walk_left   = '0;
        s.walk_right  = '0;
        s.aah         = '0;
        s.digging     = '0;
        s.jumping     = '0;
        s.splat       = '0;
        s.alive_count = '0;
        for (int i = 0; i < NUM_LEMMINGS; i++) begin
            s.walk_left[i]  = o[i].walk_left;
            s.walk_right[i] = o[i].walk_right;
            s.aah[i]        = o[i].aah;
            s.digging[i]    = o[i].digging;
            s.jumping[i]    = o[i].jumping;
            s.splat[i]      = o[i].splat;
            s.alive_count   = s.alive_count + CW'(!o[i].splat);
        end
    end
endmodule

// File: tb/tb_lemmings_array.sv
// tb_lemmings_array: directed-vector bench for a 4-lemming array, SPLAT_CYCLES=20, JUMP_CYCLES=2.
module tb_lemmings_array;
    logic clk = 1'b0;
    logic areset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   aahn;
    logic [3:0] jseq;
    lemmings_array_if #(.NUM_LEMMINGS(4)) bus ();
    lemmings_array #(.NUM_LEMMINGS(4), .SPLAT_CYCLES(20), .JUMP_CYCLES(2)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .s        (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_bumps();
        bus.bump_left = '0;
        bus.bump_right = '0;
        bus.small_bump_left = '0;
        bus.small_bump_right = '0;
        bus.dig = '0;
    endtask
    initial begin
        areset_n = 1'b0;
        clear_bumps();
        bus.ground = 4'hF;
        #1;
        check("rst_walk_left", bus.walk_left, 4'hF);
        check("rst_walk_right", bus.walk_right, 0);
        check("rst_other_outs", {bus.aah, bus.digging, bus.jumping, bus.splat}, 0);
        check("rst_alive", bus.alive_count, 4);
        @(negedge clk) areset_n = 1'b1;
        step();
        check("idle_walk_left", bus.walk_left, 4'hF);
        // large bump turns only lemming 0
        bus.bump_left = 4'b0001; step(); clear_bumps();
        check("bump_turn_right", bus.walk_right, 4'b0001);
        check("bump_others_left", bus.walk_left, 4'b1110);
        bus.bump_left = 4'b0010; step(); clear_bumps();
        check("l1_turn_right", bus.walk_right, 4'b0011);
        // trailing small bump is ignored
        bus.small_bump_left = 4'b0010; step(); clear_bumps();
        check("trail_small_jump", bus.jumping, 0);
        check("trail_small_walk", bus.walk_right, 4'b0011);
        // jump lasts exactly two cycles
        bus.small_bump_right = 4'b0010; step(); clear_bumps();
        jseq[0] = bus.jumping[1];
        step(); jseq[1] = bus.jumping[1];
        step(); jseq[2] = bus.jumping[1];
        step(); jseq[3] = bus.jumping[1];
        check("jump_seq", jseq, 4'b0011);
        check("jump_end_walk", bus.walk_right, 4'b0011);
        // 20-cycle fall survives
        bus.ground = 4'b1011; aahn = 0;
        repeat (20) begin step(); aahn += int'(bus.aah[2]); end
        bus.ground = 4'hF; step(); aahn += int'(bus.aah[2]);
        check("fall20_aah_cycles", aahn, 20);
        check("fall20_walk", bus.walk_left, 4'b1100);
        check("fall20_no_splat", bus.splat, 0);
        // 21-cycle fall splats
        bus.ground = 4'b1011; aahn = 0;
        repeat (21) begin step(); aahn += int'(bus.aah[2]); end
        bus.ground = 4'hF; step(); aahn += int'(bus.aah[2]);
        check("fall21_aah_cycles", aahn, 21);
        check("fall21_splat", bus.splat, 4'b0100);
        check("fall21_alive", bus.alive_count, 3);
        bus.bump_left = 4'b0100; bus.dig = 4'b0100; bus.ground = 4'b1011;
        repeat (3) step();
        clear_bumps(); bus.ground = 4'hF; step();
        check("splat_sticky", bus.splat, 4'b0100);
        check("splat_alive", bus.alive_count, 3);
        check("splat_only_out", {bus.walk_left[2], bus.walk_right[2], bus.aah[2], bus.digging[2], bus.jumping[2]}, 0);
        // dig, then fall through, bump during fall ignored
        bus.dig = 4'b1000; step(); clear_bumps();
        check("dig_start", bus.digging, 4'b1000);
        step();
        check("dig_hold", bus.digging, 4'b1000);
        bus.ground = 4'b0111; step();
        check("dig_fall_aah", bus.aah, 4'b1000);
        check("dig_fall_nodig", bus.digging, 0);
        bus.bump_left = 4'b1000; step(); clear_bumps();
        bus.ground = 4'hF; step();
        check("fall_bump_dir", bus.walk_left, 4'b1000);
        // fall beats dig and bump
        bus.ground = 4'b1110; bus.dig = 4'b0001; bus.bump_right = 4'b0001; bus.bump_left = 4'b0001;
        step(); clear_bumps(); bus.ground = 4'hF;
        check("prio_fall_aah", bus.aah, 4'b0001);
        check("prio_fall_nodig", bus.digging, 0);
        step();
        check("prio_land_right", bus.walk_right, 4'b0011);
        bus.bump_left = 4'b0001; bus.bump_right = 4'b0001; step(); clear_bumps();
        check("both_bumps_rev", bus.walk_left, 4'b1001);
        // jump ending over a hole falls with a fresh counter
        bus.small_bump_right = 4'b0010; step(); clear_bumps();
        check("hole_jump1", bus.jumping, 4'b0010);
        bus.ground = 4'b1101; step();
        check("hole_jump2", bus.jumping, 4'b0010);
        step();
        check("hole_fall", bus.aah, 4'b0010);
        aahn = 1;
        repeat (19) begin step(); aahn += int'(bus.aah[1]); end
        bus.ground = 4'hF; step(); aahn += int'(bus.aah[1]);
        check("hole_aah_cycles", aahn, 20);
        check("hole_survive", bus.walk_right, 4'b0010);
        check("hole_no_splat", bus.splat, 4'b0100);
        // async reset mid-fall and on the splatted lemming
        bus.ground = 4'b1110; repeat (5) step();
        check("pre_rst_fall", bus.aah, 4'b0001);
        #2 areset_n = 1'b0;
        #1;
        check("arst_walk_left", bus.walk_left, 4'hF);
        check("arst_alive", bus.alive_count, 4);
        check("arst_splat", bus.splat, 0);
        check("arst_aah", bus.aah, 0);
        bus.ground = 4'hF;
        @(negedge clk) areset_n = 1'b1;
        step();
        check("post_rst_walk", bus.walk_left, 4'hF);
        bus.ground = 4'b1010; aahn = 0;
        repeat (20) begin step(); aahn += int'(bus.aah[0]); end
        bus.ground = 4'hF; step(); aahn += int'(bus.aah[0]);
        check("fresh_aah_cycles", aahn, 20);
        check("fresh_walk", bus.walk_left, 4'hF);
        check("fresh_alive", bus.alive_count, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lemmings_array.md
# lemmings_array

Parametrised multi-lemming controller: NUM_LEMMINGS independent Moore state machines, each walking, bumping, jumping small obstacles, digging, falling, and splatting after a long fall. Successor to the single-lemming `top` controller. Adds channel count, a fall-duration death rule, a configurable jump length and a live-lemming count. Sits between the per-lemming terrain sensors and the display/score logic.

## Interface
- NUM_LEMMINGS, 4: number of independent lemmings (channels), ≥1.
- SPLAT_CYCLES, 20: maximum survivable fall, in cycles with aah=1.
- JUMP_CYCLES, 2: cycles spent jumping per small bump, ≥1.
- clk  in  1  single system clock, rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- bump_left, bump_right  in  NUM_LEMMINGS  per-lemming large obstacle on that side; reverse direction.
- small_bump_left, small_bump_right  in  NUM_LEMMINGS  per-lemming small obstacle on that side; jump over it.
- ground  in  NUM_LEMMINGS  per-lemming 1 = ground present.
- dig  in  NUM_LEMMINGS  per-lemming dig request.
- walk_left, walk_right, aah, digging, jumping, splat  out  NUM_LEMMINGS  per-lemming state outputs.
- alive_count  out  $clog2(NUM_LEMMINGS+1)  number of lemmings not in SPLAT.

## Operation
- Per lemming, states: WALK_L, WALK_R, JUMP_L, JUMP_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. Reset state WALK_L.
- Moore decode, exactly one output high per lemming:
  - WALK_x → walk_left/walk_right.
  - JUMP_x → jumping.
  - FALL_x → aah.
  - DIG_x → digging.
  - SPLAT → splat.
- WALK_d priority, highest first:
  1. ground=0 → FALL_d.
  2. dig=1 → DIG_d.
  3. Large bump on the facing side, or both large bumps → WALK_(opposite d).
  4. Small bump on the facing side → JUMP_d.
  5. Otherwise stay.
- Large/small bumps on the trailing side are ignored.
- JUMP_d: ignores all inputs; jump_cnt counts 0..JUMP_CYCLES-1. On the last cycle: ground=1 → WALK_d, ground=0 → FALL_d.
- FALL_d:
  - fall_cnt increments each cycle, saturating at SPLAT_CYCLES.
  - On ground=1: splat if fall_cnt ≥ SPLAT_CYCLES (aah was high more than SPLAT_CYCLES cycles), else WALK_d.
  - Bumps and dig are ignored.
- DIG_d: ground=0 → FALL_d; otherwise stay. Bumps and dig are ignored.
- SPLAT: absorbing; left only by areset_n.
- fall_cnt and jump_cnt clear to 0 in every state that does not use them.
- Channels share no state. alive_count = popcount(~splat), combinational from state.

## Timing
- Reset (async assert, sync to clk edge on release):
  - All lemmings WALK_L, counters 0.
  - walk_left = all ones; walk_right, aah, digging, jumping, splat = 0.
  - alive_count = NUM_LEMMINGS.
- Latency: inputs are sampled at rising edge N; the output change is visible after edge N (one-cycle state latency). There is no combinational input→output path.
- Fall survival boundary: with ground low for exactly K cycles in WALK:
  - aah is high K cycles.
  - K ≤ SPLAT_CYCLES → walk resumes.
  - K = SPLAT_CYCLES+1 → splat.
- Jump: jumping is high exactly JUMP_CYCLES consecutive cycles.
- areset_n asserted mid-fall/jump/splat forces WALK_L immediately (async), regardless of counter values.
- fall_cnt width $clog2(SPLAT_CYCLES+1); jump_cnt width $clog2(JUMP_CYCLES), minimum 1 bit. No wrap-around, since both saturate or reset.

## Structure
- Package lemmings_pkg: state enum (9 states) and a `lemming_out_t` struct of the six outputs.
- Sub-module lemming_fsm: one channel, carrying SPLAT_CYCLES and JUMP_CYCLES parameters and scalar ports.
- lemmings_array: generate loop over NUM_LEMMINGS instances, plus the alive_count popcount.

## Test plan
- Reset, then ground=1, no bumps (N=4) → walk_left=4'b1111, alive_count=4. bump_left[0] one cycle → walk_right[0]=1 next cycle; the other channels stay left.
- Lemming 1 walking right, small_bump_right[1]=1 one cycle (JUMP_CYCLES=2) → jumping[1] high exactly 2 cycles, then walk_right[1]. small_bump_left[1] while walking right → ignored.
- Fall survival, SPLAT_CYCLES=20 → ground[2] low 20 cycles gives aah 20 cycles, then walk_left. Ground low 21 cycles → splat[2]=1, alive_count=3; later inputs do not change it.
- Dig then fall: dig[3]=1 with ground=1 → digging[3]. Ground[3]=0 → aah[3] next cycle. bump_left during the fall → direction unchanged after landing.
- Simultaneous events: ground=0 together with dig=1 and bump_left → FALL wins. Both large bumps → reverse. Jump ending over ground=0 → FALL, with fall_cnt starting at 0.
- areset_n pulsed low mid-fall and on a splatted lemming → all lemmings back to walk_left, alive_count=NUM_LEMMINGS, counters cleared. A fresh 20-cycle fall survives.
